mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-master arbiter sharing one dual-port simram (independent read port and write port).
//  Sits between the cpu (master 0) and a second requester (master 1, e.g. DMA or debug).
//  Read and write channels are arbitrated independently, each round-robin.
//  Read data is returned with a per-master valid strobe.
// PARAMETERS
//  AWIDTH  16  address width, all address ports
//  DWIDTH  16  data width, all data ports
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  reset        in   1       synchronous, active-high
//  mN_rd_req_i  in   1       N=0,1: read request; addr held stable until grant
//  mN_raddr_i   in   AWIDTH  read address
//  mN_rd_gnt_o  out  1       read granted this cycle; comb. from req + state
//  mN_rdata_o   out  DWIDTH  read data; equals mem_rdata_i, qualified by rvalid
//  mN_rvalid_o  out  1       registered; high the cycle after mN_rd_gnt_o
//  mN_wr_req_i  in   1       write request; addr/data held stable until grant
//  mN_waddr_i   in   AWIDTH  write address
//  mN_wdata_i   in   DWIDTH  write data
//  mN_wr_gnt_o  out  1       write granted (write performed) this cycle; comb.
//  mem_raddr_o  out  AWIDTH  to simram raddr
//  mem_re_o     out  1       to simram re
//  mem_rdata_i  in   DWIDTH  from simram rdata; valid 1 cycle after re
//  mem_waddr_o  out  AWIDTH  to simram waddr
//  mem_wdata_o  out  DWIDTH  to simram wdata
//  mem_we_o     out  1       to simram we
// BEHAVIOUR
//  - State per channel: 1-bit priority pointer rd_pri / wr_pri (master currently favoured).
//    State for returns: registered rd_tag (granted master) and rd_pend.
//  - Grant rule, per channel:
//    - Only one master requesting: that master is granted.
//    - Both requesting: master == pri is granted.
//    - Neither requesting: no grant.
//    - At most one grant per channel per cycle; pri <= ~granted master on any grant, else holds.
//  - A single master requesting every cycle is granted every cycle (no bubbles).
//    Two masters contending alternate 0,1,0,1.
//  - mem_re_o = |rd grants; mem_raddr_o = granted master's raddr, 0 when no grant.
//    Write channel is identical: mem_we_o, mem_waddr_o, mem_wdata_o; 0 when no grant.
//  - Read latency: grant in cycle T -> mN_rvalid_o=1 in cycle T+1 with mN_rdata_o = mem_rdata_i.
//    Fully pipelined: a new grant in T+1 is allowed.
//  - Read and write may be granted in the same cycle, including to the same master or address.
//    Same-address data ordering is the simram's behaviour; the arbiter does not reorder.
//  - A request dropped before its grant is legal (withdrawn); it has no effect beyond that cycle.
//  - Reset (reset=1 in cycle T):
//    - All gnt, mem_re_o, mem_we_o forced 0 in T; addr/data outputs 0.
//    - In T+1: rd_pri=wr_pri=0 (master 0 favoured), rd_pend=0, m0/m1_rvalid_o=0.
//    - A read granted in T-1 still returns rvalid in T unless reset is asserted; no valid ever
//      emerges for a cycle in which reset was high.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined:
//    - Adds outputs m0_stall_o and m1_stall_o, each 16-bit.
//    - Each counts cycles where that master has (rd_req & ~rd_gnt) | (wr_req & ~wr_gnt).
//    - Counters saturate at 16'hFFFF and clear to 0 on reset.
//  MEM_ARB_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  - m0 read 0x0010 alone, m1 idle -> m0_rd_gnt=1 same cycle, mem_raddr=0x0010; m0_rvalid=1 next
//    cycle with rdata=mem[0x0010].
//  - m0,m1 both hold rd_req 4 cycles after reset -> grants m0,m1,m0,m1.
//    rvalid follows one cycle later in the same order, each with its own data.
//  - m0 write 0x0020<=0xBEEF and m1 read 0x0030 in the same cycle -> both granted.
//    mem_we=1 and mem_re=1 in that cycle.
//  - m1 wr_req held while m0 wr_req toggles every cycle -> m1 granted at least every 2nd cycle
//    (no starvation).
//  - reset asserted in the cycle after a read grant -> rvalid=0 that cycle.
//    Priority returns to m0: next contended grant goes to m0.
//  - MEM_ARB_STATS_EN: 3 contended read cycles starting with m0 priority -> m1_stall_o=2,
//    m0_stall_o=1; reset -> both 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter for a dual-port simram
//
// Master 0 (cpu) and master 1 (dma/debug) share one memory with an independent
// read port and write port. Each channel has its own round-robin pointer.
// Read data returns one cycle after the grant with a per-master valid strobe.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   mN_rd_req_i, mN_raddr_i     read request / address (N = 0, 1)
//   mN_rd_gnt_o                 read grant, combinational
//   mN_rdata_o, mN_rvalid_o     read data (memory passthrough) and its strobe
//   mN_wr_req_i, mN_waddr_i,
//   mN_wdata_i                  write request / address / data
//   mN_wr_gnt_o                 write grant (write performed), combinational
//   mem_raddr_o, mem_re_o,
//   mem_rdata_i                 simram read port
//   mem_waddr_o, mem_wdata_o,
//   mem_we_o                    simram write port
//   m0_stall_o, m1_stall_o      saturating stall counters (MEM_ARB_STATS_EN only)
//
// Configuration macro: MEM_ARB_STATS_EN adds the stall counters.

module mem_arbiter #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_rd_req_i,
    input  logic [AWIDTH-1:0] m0_raddr_i,
    output logic              m0_rd_gnt_o,
    output logic [DWIDTH-1:0] m0_rdata_o,
    output logic              m0_rvalid_o,
    input  logic              m0_wr_req_i,
    input  logic [AWIDTH-1:0] m0_waddr_i,
    input  logic [DWIDTH-1:0] m0_wdata_i,
    output logic              m0_wr_gnt_o,
    input  logic              m1_rd_req_i,
    input  logic [AWIDTH-1:0] m1_raddr_i,
    output logic              m1_rd_gnt_o,
    output logic [DWIDTH-1:0] m1_rdata_o,
    output logic              m1_rvalid_o,
    input  logic              m1_wr_req_i,
    input  logic [AWIDTH-1:0] m1_waddr_i,
    input  logic [DWIDTH-1:0] m1_wdata_i,
    output logic              m1_wr_gnt_o,
    output logic [AWIDTH-1:0] mem_raddr_o,
    output logic              mem_re_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic [AWIDTH-1:0] mem_waddr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic              mem_we_o
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       m0_stall_o,
    output logic [15:0]       m1_stall_o
`endif
);

    // Pointer value = master favoured when both request.
    logic rd_pri;
    logic wr_pri;
    // Outstanding read return: rd_tag records which master it belongs to.
    logic rd_pend;
    logic rd_tag;

    always_comb begin
        m0_rd_gnt_o = 1'b0;
        m1_rd_gnt_o = 1'b0;
        m0_wr_gnt_o = 1'b0;
        m1_wr_gnt_o = 1'b0;
        if (!reset) begin
            if (m0_rd_req_i && (!m1_rd_req_i || !rd_pri))
                m0_rd_gnt_o = 1'b1;
            else if (m1_rd_req_i)
                m1_rd_gnt_o = 1'b1;

            if (m0_wr_req_i && (!m1_wr_req_i || !wr_pri))
                m0_wr_gnt_o = 1'b1;
            else if (m1_wr_req_i)
                m1_wr_gnt_o = 1'b1;
        end
    end

    always_comb begin
        mem_re_o    = m0_rd_gnt_o | m1_rd_gnt_o;
        mem_we_o    = m0_wr_gnt_o | m1_wr_gnt_o;
        mem_raddr_o = '0;
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        if (m0_rd_gnt_o)
            mem_raddr_o = m0_raddr_i;
        else if (m1_rd_gnt_o)
            mem_raddr_o = m1_raddr_i;
        if (m0_wr_gnt_o) begin
            mem_waddr_o = m0_waddr_i;
            mem_wdata_o = m0_wdata_i;
        end else if (m1_wr_gnt_o) begin
            mem_waddr_o = m1_waddr_i;
            mem_wdata_o = m1_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pri  <= 1'b0;
            wr_pri  <= 1'b0;
            rd_pend <= 1'b0;
            rd_tag  <= 1'b0;
        end else begin
            // After a grant the other master is favoured: a grant to m0 sets the pointer to 1.
            if (mem_re_o)
                rd_pri <= m0_rd_gnt_o;
            if (mem_we_o)
                wr_pri <= m0_wr_gnt_o;
            rd_pend <= mem_re_o;
            rd_tag  <= m1_rd_gnt_o;
        end
    end

    // The valid is killed in a reset cycle so a return from the previous cycle never escapes.
    assign m0_rvalid_o = rd_pend & ~rd_tag & ~reset;
    assign m1_rvalid_o = rd_pend &  rd_tag & ~reset;
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;

`ifdef MEM_ARB_STATS_EN
    logic m0_stall;
    logic m1_stall;

    assign m0_stall = (m0_rd_req_i & ~m0_rd_gnt_o) | (m0_wr_req_i & ~m0_wr_gnt_o);
    assign m1_stall = (m1_rd_req_i & ~m1_rd_gnt_o) | (m1_wr_req_i & ~m1_wr_gnt_o);

    always_ff @(posedge clk) begin
        if (reset) begin
            m0_stall_o <= '0;
            m1_stall_o <= '0;
        end else begin
            if (m0_stall && m0_stall_o != 16'hFFFF)
                m0_stall_o <= m0_stall_o + 16'd1;
            if (m1_stall && m1_stall_o != 16'hFFFF)
                m1_stall_o <= m1_stall_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_rd_req, m1_rd_req, m0_wr_req, m1_wr_req;
    logic [15:0] m0_raddr, m1_raddr, m0_waddr, m1_waddr, m0_wdata, m1_wdata;
    logic        m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_rvalid, m1_rvalid;
    logic [15:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] m0_stall, m1_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(16), .DWIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .m0_rd_req_i(m0_rd_req), .m0_raddr_i(m0_raddr), .m0_rd_gnt_o(m0_rd_gnt),
        .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
        .m0_wr_req_i(m0_wr_req), .m0_waddr_i(m0_waddr), .m0_wdata_i(m0_wdata),
        .m0_wr_gnt_o(m0_wr_gnt),
        .m1_rd_req_i(m1_rd_req), .m1_raddr_i(m1_raddr), .m1_rd_gnt_o(m1_rd_gnt),
        .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid),
        .m1_wr_req_i(m1_wr_req), .m1_waddr_i(m1_waddr), .m1_wdata_i(m1_wdata),
        .m1_wr_gnt_o(m1_wr_gnt),
        .mem_raddr_o(mem_raddr), .mem_re_o(mem_re), .mem_rdata_i(mem_rdata),
        .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we)
`ifdef MEM_ARB_STATS_EN
        , .m0_stall_o(m0_stall), .m1_stall_o(m1_stall)
`endif
    );

    // Simple dual-port memory model: registered read, write on posedge.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_raddr[7:0]];
    end

    typedef struct {
        logic        r0;  logic [15:0] ra0;
        logic        r1;  logic [15:0] ra1;
        logic        w0;  logic [15:0] wa0; logic [15:0] wd0;
        logic        w1;  logic [15:0] wa1; logic [15:0] wd1;
        logic [3:0]  eg;      // {rg0, rg1, wg0, wg1}
        logic [15:0] eraddr;
        logic [15:0] ewaddr;
        logic [15:0] ewdata;
        logic [1:0]  erv;     // {rv0, rv1}
        logic [15:0] erdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        m0_rd_req = 0; m1_rd_req = 0; m0_wr_req = 0; m1_wr_req = 0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        idle_reqs();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
        mem_rdata = 16'h0;

        vecs[0] = '{1'b1,16'h0010, 1'b0,16'h0000, 1'b0,16'h0000,16'h0000, 1'b0,16'h0000,16'h0000,
                    4'b1000, 16'h0010,16'h0000,16'h0000, 2'b00,16'h0000};
        vecs[1] = '{1'b0,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000,16'h0000, 1'b0,16'h0000,16'h0000,
                    4'b0000, 16'h0000,16'h0000,16'h0000, 2'b10,16'hA510};
        vecs[2] = '{1'b1,16'h0011, 1'b1,16'h0021, 1'b0,16'h0000,16'h0000, 1'b0,16'h0000,16'h0000,
                    4'b0100, 16'h0021,16'h0000,16'h0000, 2'b00,16'h0000};
        vecs[3] = '{1'b1,16'h0011, 1'b1,16'h0021, 1'b0,16'h0000,16'h0000, 1'b0,16'h0000,16'h0000,
                    4'b1000, 16'h0011,16'h0000,16'h0000, 2'b01,16'hA521};
        vecs[4] = '{1'b0,16'h0000, 1'b1,16'h0030, 1'b1,16'h0020,16'hBEEF, 1'b0,16'h0000,16'h0000,
                    4'b0110, 16'h0030,16'h0020,16'hBEEF, 2'b10,16'hA511};
        vecs[5] = '{1'b1,16'h0020, 1'b0,16'h0000, 1'b1,16'h0040,16'h1111, 1'b1,16'h0041,16'h2222,
                    4'b1001, 16'h0020,16'h0041,16'h2222, 2'b01,16'hA530};
        vecs[6] = '{1'b0,16'h0000, 1'b0,16'h0000, 1'b1,16'h0042,16'h3333, 1'b0,16'h0000,16'h0000,
                    4'b0010, 16'h0000,16'h0042,16'h3333, 2'b10,16'hBEEF};
        vecs[7] = '{1'b0,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000,16'h0000, 1'b0,16'h0000,16'h0000,
                    4'b0000, 16'h0000,16'h0000,16'h0000, 2'b00,16'h0000};

        // Reset with every request asserted: nothing may be granted.
        reset = 1'b1;
        m0_rd_req = 1; m1_rd_req = 1; m0_wr_req = 1; m1_wr_req = 1;
        m0_raddr = 16'h1; m1_raddr = 16'h2; m0_waddr = 16'h3; m1_waddr = 16'h4;
        m0_wdata = 16'h5; m1_wdata = 16'h6;
        #2;
        chk("rst_gnts", {m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt}, 4'b0000);
        chk("rst_re_we", {mem_re, mem_we}, 2'b00);
        chk("rst_addrs", {mem_raddr, mem_waddr}, 32'h0);
        chk("rst_wdata", mem_wdata, 16'h0);
        tick();
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        reset = 1'b0;
        idle_reqs();
        #3;
        chk("post_rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        tick();

        // Table-driven vectors, one per cycle.
        for (int i = 0; i < 8; i++) begin
            m0_rd_req = vecs[i].r0; m0_raddr = vecs[i].ra0;
            m1_rd_req = vecs[i].r1; m1_raddr = vecs[i].ra1;
            m0_wr_req = vecs[i].w0; m0_waddr = vecs[i].wa0; m0_wdata = vecs[i].wd0;
            m1_wr_req = vecs[i].w1; m1_waddr = vecs[i].wa1; m1_wdata = vecs[i].wd1;
            #3;
            chk($sformatf("v%0d_gnt", i), {m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt}, vecs[i].eg);
            chk($sformatf("v%0d_re", i), mem_re, vecs[i].eg[3] | vecs[i].eg[2]);
            chk($sformatf("v%0d_we", i), mem_we, vecs[i].eg[1] | vecs[i].eg[0]);
            chk($sformatf("v%0d_raddr", i), mem_raddr, vecs[i].eraddr);
            chk($sformatf("v%0d_waddr", i), mem_waddr, vecs[i].ewaddr);
            chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].ewdata);
            chk($sformatf("v%0d_rvalid", i), {m0_rvalid, m1_rvalid}, vecs[i].erv);
            if (vecs[i].erv[1]) chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].erdata);
            if (vecs[i].erv[0]) chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].erdata);
            tick();
        end

        // Contended reads after reset alternate m0, m1, m0, m1 with returns in order.
        reset_dut();
        m0_raddr = 16'h0050; m1_raddr = 16'h0060;
        for (int k = 0; k < 5; k++) begin
            m0_rd_req = (k < 4); m1_rd_req = (k < 4);
            #3;
            if (k < 4)
                chk($sformatf("rr%0d_gnt", k), {m0_rd_gnt, m1_rd_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k > 0) begin
                chk($sformatf("rr%0d_rvalid", k), {m0_rvalid, m1_rvalid}, (k % 2 == 1) ? 2'b10 : 2'b01);
                chk($sformatf("rr%0d_rdata", k), (k % 2 == 1) ? m0_rdata : m1_rdata,
                    (k % 2 == 1) ? 16'hA550 : 16'hA560);
            end
            tick();
        end
        idle_reqs();

        // m1 write held, m0 write toggling: m1 never misses two cycles in a row.
        begin
            int miss = 0;
            m1_wr_req = 1; m1_waddr = 16'h0080; m1_wdata = 16'h0001;
            m0_waddr = 16'h0081; m0_wdata = 16'h0002;
            for (int k = 0; k < 8; k++) begin
                m0_wr_req = k[0];
                #3;
                miss = m1_wr_gnt ? 0 : miss + 1;
                chk($sformatf("starve%0d", k), miss, (miss < 2) ? miss : 1);
                if (!m0_wr_req) chk($sformatf("starve%0d_alone", k), m1_wr_gnt, 1'b1);
                chk($sformatf("starve%0d_one", k), m0_wr_gnt & m1_wr_gnt, 1'b0);
                tick();
            end
            idle_reqs();
        end

        // Reset in the cycle after a read grant suppresses the return and restores m0 priority.
        reset_dut();
        m0_rd_req = 1; m0_raddr = 16'h0070;
        #3;
        chk("rg_pre_gnt", {m0_rd_gnt, m1_rd_gnt}, 2'b10);
        tick();
        reset = 1'b1; m1_rd_req = 1; m1_raddr = 16'h0071;
        #3;
        chk("rg_rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        chk("rg_rst_gnt", {m0_rd_gnt, m1_rd_gnt, mem_re}, 3'b000);
        tick();
        reset = 1'b0;
        #3;
        chk("rg_post_gnt", {m0_rd_gnt, m1_rd_gnt}, 2'b10);
        chk("rg_post_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        tick();
        idle_reqs();

`ifdef MEM_ARB_STATS_EN
        reset_dut();
        m0_rd_req = 1; m1_rd_req = 1;
        tick(); tick(); tick();
        idle_reqs();
        #3;
        chk("stall_m0", m0_stall, 16'd1);
        chk("stall_m1", m1_stall, 16'd2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("stall_rst", {m0_stall, m1_stall}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
